i281_exec_ctrl: RTL and testbench

Execution controller for the i281 multicycle CPU. It produces the single clock-enable that advances the control FSM state register and every datapath register, so the core can free-run, halt, single-step one instruction or single-step one cycle. It stops only on instruction boundaries (control FSM in IF) and supports one PC breakpoint. It also keeps cycle and instruction counters. It sits between the board run/step inputs and the control FSM / datapath.

---
 rtl/i281_exec_pkg.sv | 14 +
 rtl/i281_exec_ctrl_if.sv | 40 ++++
 rtl/i281_sat_counter.sv | 42 ++++
 rtl/i281_exec_ctrl.sv | 137 +++++++++++++
 tb/tb_i281_exec_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i281_exec_pkg.sv
// Shared definitions for the i281 execution controller: exec_state
// encoding and default widths.
package i281_exec_pkg;

   localparam int PC_WIDTH_DEF  = 6;
   localparam int CNT_WIDTH_DEF = 16;

   // exec_state encoding, visible on the exec_state output
   localparam logic [1:0] ST_HALT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_STEP_I = 2'd2;
   localparam logic [1:0] ST_STEP_C = 2'd3;

endpackage

// File: rtl/i281_exec_ctrl_if.sv
// Run/step controls, breakpoint setup, FSM status and counter outputs
// exchanged between the board/debug side and the execution controller.
interface i281_exec_ctrl_if
   import i281_exec_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
);

   logic                 run;
   logic                 step_instr;
   logic                 step_cycle;
   logic                 halt_req;
   logic                 fsm_at_if;
   logic [PC_WIDTH-1:0]  pc;
   logic                 bp_enable;
   logic [PC_WIDTH-1:0]  bp_addr;
   logic                 cnt_clear;

   logic                 cpu_en;
   logic [1:0]           exec_state;
   logic                 bp_hit;
   logic [CNT_WIDTH-1:0] cycle_count;
   logic [CNT_WIDTH-1:0] instr_count;

   // Board/debug side: drives controls, observes status
   modport master (
      output run, step_instr, step_cycle, halt_req, fsm_at_if, pc,
             bp_enable, bp_addr, cnt_clear,
      input  cpu_en, exec_state, bp_hit, cycle_count, instr_count
   );

   // Execution controller side
   modport slave (
      input  run, step_instr, step_cycle, halt_req, fsm_at_if, pc,
             bp_enable, bp_addr, cnt_clear,
      output cpu_en, exec_state, bp_hit, cycle_count, instr_count
   );

endinterface

// File: rtl/i281_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count holds at all-ones.
module i281_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear first, otherwise increment unless already saturated
   always_comb begin
      // NOTE: count_d is defaulted before any branch so every path assigns it and no latch is inferred.
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX)) begin
         count_d = count_q + ONE;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/i281_exec_ctrl.sv
// i281 execution controller: generates the single clock-enable for the
// control FSM and datapath so the core can free-run, halt on instruction
// boundaries, single-step an instruction or a cycle, and stop on a PC
// breakpoint. Also keeps saturating cycle and instruction counters.
module i281_exec_ctrl
   import i281_exec_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input logic             clk,
   input logic             rst,
   i281_exec_ctrl_if.slave bus
);

   logic [1:0]           state_q, state_d;
   logic                 first_q, first_d;
   logic                 halt_pending_q, halt_pending_d;
   logic                 bp_hit_q, bp_hit_d;

   logic [PC_WIDTH-1:0]  pc_w;
   logic [PC_WIDTH-1:0]  bp_addr_w;
   logic                 bp_match;
   logic                 exit_cond;
   logic                 stop;
   logic                 cpu_en;
   logic                 instr_inc;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic [CNT_WIDTH-1:0] instr_cnt;

   assign pc_w      = bus.pc;
   assign bp_addr_w = bus.bp_addr;
   assign bp_match  = bus.bp_enable & (pc_w == bp_addr_w);

   // Stop decision and clock-enable; stops are only taken at an IF boundary
   // and never on the first enabled cycle after leaving HALT
   always_comb begin
      exit_cond = 1'b1;
      if (state_q == ST_RUN) begin
         exit_cond = ~bus.run;
      end
      stop   = ~first_q & bus.fsm_at_if & (bp_match | halt_pending_q | exit_cond);
      cpu_en = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP_I: cpu_en = ~stop;
         ST_STEP_C:         cpu_en = 1'b1;
         default:           cpu_en = 1'b0;
      endcase
   end

   // Next exec_state, resume flag, pending halt and sticky breakpoint flag
   always_comb begin
      state_d        = state_q;
      first_d        = first_q;
      halt_pending_d = halt_pending_q;
      bp_hit_d       = bp_hit_q;

      case (state_q)
         ST_HALT: begin
            // step_cycle outranks step_instr, which outranks run
            if (bus.step_cycle) begin
               state_d = ST_STEP_C;
            end else if (bus.step_instr) begin
               state_d = ST_STEP_I;
            end else if (bus.run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_STEP_I: begin
            if (stop) begin
               state_d = ST_HALT;
               if (bp_match) begin
                  bp_hit_d = 1'b1;
               end
            end
         end
         default: begin
            // STEP_C is exactly one enabled cycle, wherever the FSM is
            state_d = ST_HALT;
         end
      endcase

      if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
         first_d  = 1'b1;
         bp_hit_d = 1'b0;
      end else if (cpu_en) begin
         first_d = 1'b0;
      end

      // halt_req is ignored while halted; a pending halt is consumed on entry to HALT
      if ((state_q == ST_HALT) || (state_d == ST_HALT)) begin
         halt_pending_d = 1'b0;
      end else if (bus.halt_req) begin
         halt_pending_d = 1'b1;
      end
   end

   // Controller state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_HALT;
         first_q        <= 1'b0;
         halt_pending_q <= 1'b0;
         bp_hit_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         first_q        <= first_d;
         halt_pending_q <= halt_pending_d;
         bp_hit_q       <= bp_hit_d;
      end
   end

   assign instr_inc = cpu_en & bus.fsm_at_if;

   i281_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (bus.cnt_clear),
      .inc_i   (cpu_en),
      .count_o (cycle_cnt)
   );

   i281_sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (bus.cnt_clear),
      .inc_i   (instr_inc),
      .count_o (instr_cnt)
   );

   assign bus.cpu_en      = cpu_en;
   assign bus.exec_state  = state_q;
   assign bus.bp_hit      = bp_hit_q;
   assign bus.cycle_count = cycle_cnt;
   assign bus.instr_count = instr_cnt;

endmodule

// File: tb/tb_i281_exec_ctrl.sv
// Self-checking bench for i281_exec_ctrl: a directed vector table, hand
// sequences for reset, breakpoint and counter saturation, and a random
// phase checked against a behavioural model of the run/step rules. The
// control FSM is modelled as 4-cycle instructions with PC advancing at
// the end of each instruction.
module tb_i281_exec_ctrl;

   localparam int PCW     = 6;
   localparam int CNTW    = 16;
   localparam int CNT_MAX = 65535;

   localparam int M_HALT   = 0;
   localparam int M_RUN    = 1;
   localparam int M_STEP_I = 2;
   localparam int M_STEP_C = 3;

   typedef struct packed {
      logic        run;
      logic        si;
      logic        sc;
      logic        hr;
      logic        clr;
      logic        en;
      logic [1:0]  st;
      logic [15:0] cyc;
      logic [15:0] ins;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_s = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   i281_exec_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CNTW)) bus ();
   i281_exec_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(4))    bus_s ();

   i281_exec_ctrl #(.PC_WIDTH(PCW), .CNT_WIDTH(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Narrow-counter instance so saturation is reachable in a few cycles
   i281_exec_ctrl #(.PC_WIDTH(PCW), .CNT_WIDTH(4)) dut_s (
      .clk (clk),
      .rst (rst_s),
      .bus (bus_s)
   );

   always #5 clk = ~clk;

   // Reference model state
   int m_mode;
   bit m_fresh;
   bit m_halt_ask;
   bit m_bp;
   bit m_en;
   bit m_bp_now;
   int m_cyc;
   int m_ins;
   // Environment: control FSM phase (0 = IF) and program counter
   int ef;
   int epc;

   // Values sampled from the DUT mid-cycle by tick()
   logic        s_en;
   logic [1:0]  s_st;
   logic        s_bp;
   logic [15:0] s_cyc;
   logic [15:0] s_ins;

   vec_t vecs[37];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic run, input logic si, input logic sc, input logic hr,
                               input logic clr, input logic en, input logic [1:0] st,
                               input int cyc, input int ins);
      vec_t v;
      v.run = run; v.si = si; v.sc = sc; v.hr = hr; v.clr = clr;
      v.en = en; v.st = st; v.cyc = 16'(cyc); v.ins = 16'(ins);
      return v;
   endfunction

   task automatic model_reset();
      m_mode = M_HALT; m_fresh = 0; m_halt_ask = 0; m_bp = 0;
      m_en = 0; m_bp_now = 0; m_cyc = 0; m_ins = 0;
      ef = 0; epc = 0;
   endtask

   // Is the core allowed to advance this cycle?
   task automatic model_eval();
      bit wants_stop;
      m_bp_now   = bus.bp_enable && (int'(bus.bp_addr) == epc);
      wants_stop = !m_fresh && (ef == 0) &&
                   (m_bp_now || m_halt_ask || (m_mode == M_STEP_I) || (m_mode == M_RUN && !bus.run));
      if (m_mode == M_HALT)        m_en = 0;
      else if (m_mode == M_STEP_C) m_en = 1;
      else                         m_en = !wants_stop;
   endtask

   // Apply one clock edge to the model and the environment
   task automatic model_step();
      int prev;
      prev = m_mode;
      if (bus.cnt_clear) begin
         m_cyc = 0;
         m_ins = 0;
      end else begin
         if (m_en && m_cyc < CNT_MAX) m_cyc++;
         if (m_en && ef == 0 && m_ins < CNT_MAX) m_ins++;
      end
      if (prev == M_HALT) begin
         if (bus.step_cycle)      m_mode = M_STEP_C;
         else if (bus.step_instr) m_mode = M_STEP_I;
         else if (bus.run)        m_mode = M_RUN;
      end else if (prev == M_STEP_C) begin
         m_mode = M_HALT;
      end else if (!m_en) begin
         m_mode = M_HALT;
         if (m_bp_now) m_bp = 1;
      end
      if (prev == M_HALT || m_mode == M_HALT) m_halt_ask = 0;
      else if (bus.halt_req)                  m_halt_ask = 1;
      if (prev == M_HALT && m_mode != M_HALT) begin
         m_fresh = 1;
         m_bp    = 0;
      end else if (m_en) begin
         m_fresh = 0;
      end
      if (m_en) begin
         if (ef == 3) begin
            ef  = 0;
            epc = (epc + 1) % 64;
         end else begin
            ef++;
         end
      end
   endtask

   // One clock cycle: called just after a rising edge with inputs set;
   // samples and checks mid-cycle, then advances through the next edge.
   task automatic tick();
      bus.fsm_at_if = (ef == 0);
      bus.pc        = 6'(epc);
      #3;
      model_eval();
      s_en  = bus.cpu_en;
      s_st  = bus.exec_state;
      s_bp  = bus.bp_hit;
      s_cyc = bus.cycle_count;
      s_ins = bus.instr_count;
      check("cpu_en", 32'(s_en), 32'(m_en));
      check("exec_state", 32'(s_st), 32'(m_mode));
      check("bp_hit", 32'(s_bp), 32'(m_bp));
      check("cycle_count", 32'(s_cyc), 32'(m_cyc));
      check("instr_count", 32'(s_ins), 32'(m_ins));
      @(posedge clk);
      model_step();
      #1;
      bus.step_instr = 1'b0;
      bus.step_cycle = 1'b0;
      bus.halt_req   = 1'b0;
      bus.cnt_clear  = 1'b0;
      bus.fsm_at_if  = (ef == 0);
      bus.pc         = 6'(epc);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int en_cnt;

      // run si sc hr clr | en st cyc ins   (expected values seen mid-cycle)
      vecs[0]  = mk(0,0,0,0,0, 0,0,  0,0);
      vecs[1]  = mk(0,1,0,0,0, 0,0,  0,0);
      vecs[2]  = mk(0,0,0,0,0, 1,2,  0,0);
      vecs[3]  = mk(0,0,0,0,0, 1,2,  1,1);
      vecs[4]  = mk(0,0,0,0,0, 1,2,  2,1);
      vecs[5]  = mk(0,0,0,0,0, 1,2,  3,1);
      vecs[6]  = mk(0,0,0,0,0, 0,2,  4,1);
      vecs[7]  = mk(0,0,0,0,0, 0,0,  4,1);
      vecs[8]  = mk(0,0,1,0,0, 0,0,  4,1);
      vecs[9]  = mk(0,0,0,0,0, 1,3,  4,1);
      vecs[10] = mk(0,0,1,0,0, 0,0,  5,2);
      vecs[11] = mk(0,0,0,0,0, 1,3,  5,2);
      vecs[12] = mk(0,0,1,0,0, 0,0,  6,2);
      vecs[13] = mk(0,0,0,0,0, 1,3,  6,2);
      vecs[14] = mk(0,0,0,0,0, 0,0,  7,2);
      vecs[15] = mk(0,1,0,0,0, 0,0,  7,2);
      vecs[16] = mk(0,0,0,0,0, 1,2,  7,2);
      vecs[17] = mk(0,0,0,0,0, 0,2,  8,2);
      vecs[18] = mk(0,0,0,0,0, 0,0,  8,2);
      vecs[19] = mk(1,1,1,0,0, 0,0,  8,2);
      vecs[20] = mk(0,0,0,0,0, 1,3,  8,2);
      vecs[21] = mk(0,0,0,0,0, 0,0,  9,3);
      vecs[22] = mk(1,0,0,0,0, 0,0,  9,3);
      vecs[23] = mk(1,0,0,0,0, 1,1,  9,3);
      vecs[24] = mk(1,0,0,1,0, 1,1, 10,3);
      vecs[25] = mk(1,0,0,0,0, 1,1, 11,3);
      vecs[26] = mk(1,0,0,0,0, 0,1, 12,3);
      vecs[27] = mk(0,0,0,0,0, 0,0, 12,3);
      vecs[28] = mk(1,0,0,0,0, 0,0, 12,3);
      vecs[29] = mk(1,0,0,0,0, 1,1, 12,3);
      vecs[30] = mk(0,0,0,0,0, 1,1, 13,4);
      vecs[31] = mk(0,0,0,0,0, 1,1, 14,4);
      vecs[32] = mk(0,0,0,0,0, 1,1, 15,4);
      vecs[33] = mk(0,0,0,0,0, 0,1, 16,4);
      vecs[34] = mk(0,0,0,0,0, 0,0, 16,4);
      vecs[35] = mk(0,0,0,0,1, 0,0, 16,4);
      vecs[36] = mk(0,0,0,0,0, 0,0,  0,0);

      bus.run = 0; bus.step_instr = 0; bus.step_cycle = 0; bus.halt_req = 0;
      bus.fsm_at_if = 1; bus.pc = '0; bus.bp_enable = 0; bus.bp_addr = '0; bus.cnt_clear = 0;
      bus_s.run = 0; bus_s.step_instr = 0; bus_s.step_cycle = 0; bus_s.halt_req = 0;
      bus_s.fsm_at_if = 0; bus_s.pc = '0; bus_s.bp_enable = 0; bus_s.bp_addr = '0; bus_s.cnt_clear = 0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // Directed vectors: step_instr, step_cycle x3 + step_instr, priority,
      // halt_req mid-instruction, run dropped mid-instruction, cnt_clear
      for (int i = 0; i < 37; i++) begin
         bus.run        = vecs[i].run;
         bus.step_instr = vecs[i].si;
         bus.step_cycle = vecs[i].sc;
         bus.halt_req   = vecs[i].hr;
         bus.cnt_clear  = vecs[i].clr;
         tick();
         check($sformatf("vec%0d_cpu_en", i), 32'(s_en), 32'(vecs[i].en));
         check($sformatf("vec%0d_state", i), 32'(s_st), 32'(vecs[i].st));
         check($sformatf("vec%0d_cycles", i), 32'(s_cyc), 32'(vecs[i].cyc));
         check($sformatf("vec%0d_instrs", i), 32'(s_ins), 32'(vecs[i].ins));
         check($sformatf("vec%0d_bp_hit", i), 32'(s_bp), 32'(0));
      end

      // Reset while running with cycle_count at 37
      bus.run = 1;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_cyc == 37) begin
            found = 1;
            break;
         end
      end
      check("reach_37_cycles", 32'(found), 32'(1));
      check("pre_reset_cycle_count", 32'(bus.cycle_count), 32'(37));
      check("pre_reset_running", 32'(bus.exec_state), 32'(M_RUN));
      #2;
      rst = 1;
      #1;
      check("reset_exec_state", 32'(bus.exec_state), 32'(0));
      check("reset_cpu_en", 32'(bus.cpu_en), 32'(0));
      check("reset_cycle_count", 32'(bus.cycle_count), 32'(0));
      check("reset_instr_count", 32'(bus.instr_count), 32'(0));
      bus.run = 0;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();

      // Breakpoint at PC 5, then step past it with run still high
      bus.bp_enable = 1;
      bus.bp_addr   = 6'd5;
      bus.run       = 1;
      tick();
      found = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (m_mode == M_HALT) begin
            found = 1;
            break;
         end
      end
      check("bp_stop_reached", 32'(found), 32'(1));
      check("bp_stop_pc", 32'(bus.pc), 32'(5));
      check("bp_stop_state", 32'(bus.exec_state), 32'(M_HALT));
      check("bp_stop_bp_hit", 32'(bus.bp_hit), 32'(1));
      check("bp_stop_cycles", 32'(bus.cycle_count), 32'(20));
      check("bp_stop_instrs", 32'(bus.instr_count), 32'(5));

      bus.step_instr = 1;
      tick();
      en_cnt = 0;
      found  = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (s_en === 1'b1) en_cnt++;
         if (m_mode == M_HALT) begin
            found = 1;
            break;
         end
      end
      check("bp_step_done", 32'(found), 32'(1));
      check("bp_step_en_cycles", 32'(en_cnt), 32'(4));
      check("bp_step_pc", 32'(bus.pc), 32'(6));
      check("bp_step_state", 32'(bus.exec_state), 32'(M_HALT));
      check("bp_step_bp_hit", 32'(bus.bp_hit), 32'(0));
      check("bp_step_cycles", 32'(bus.cycle_count), 32'(24));
      check("bp_step_instrs", 32'(bus.instr_count), 32'(6));
      bus.run       = 0;
      bus.bp_enable = 0;
      tick();

      // Saturation on the 4-bit instance: free-run with the FSM never at IF
      rst_s = 0;
      bus_s.run = 1;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus_s.cycle_count == 4'hE) begin
            found = 1;
            break;
         end
      end
      check("sat_preload_reached", 32'(found), 32'(1));
      repeat (5) @(posedge clk);
      #1;
      check("sat_cycle_count", 32'(bus_s.cycle_count), 32'(4'hF));
      check("sat_instr_count", 32'(bus_s.instr_count), 32'(0));
      check("sat_state_run", 32'(bus_s.exec_state), 32'(M_RUN));
      check("sat_cpu_en", 32'(bus_s.cpu_en), 32'(1));
      bus_s.cnt_clear = 1;
      @(posedge clk);
      #1;
      bus_s.cnt_clear = 0;
      check("clear_beats_inc", 32'(bus_s.cycle_count), 32'(0));
      @(posedge clk);
      #1;
      check("count_after_clear", 32'(bus_s.cycle_count), 32'(1));
      bus_s.run = 0;

      // Random run/step/halt/breakpoint traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
         bus.step_instr = ($urandom_range(0, 14) == 0);
         bus.step_cycle = ($urandom_range(0, 14) == 0);
         bus.halt_req   = ($urandom_range(0, 11) == 0);
         bus.cnt_clear  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 39) == 0) begin
            bus.bp_enable = 1'($urandom_range(0, 1));
            bus.bp_addr   = 6'((epc + int'($urandom_range(0, 3))) % 64);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
